alu_share_arbiter: RTL and testbench

//  Shares one combinational ALU between two requesters (e.g. issue slot and address-gen unit).

---
 rtl/alu_share_arbiter.sv | 121 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin arbiter in front of a shared combinational ALU.
// One op in flight: IDLE accepts, EXEC drives the ALU from registered operands,
// RESP holds the captured result until the owning requester takes it.
module alu_share_arbiter #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned CTRL_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*WIDTH-1:0]  req_a,
  input  logic [2*WIDTH-1:0]  req_b,
  input  logic [2*CTRL_W-1:0] req_ctrl,
  output logic [1:0]          resp_valid,
  input  logic [1:0]          resp_ready,
  output logic [WIDTH-1:0]    resp_result,
  output logic                resp_zero,
  output logic [WIDTH-1:0]    alu_a,
  output logic [WIDTH-1:0]    alu_b,
  output logic [CTRL_W-1:0]   alu_ctrl,
  input  logic [WIDTH-1:0]    alu_result,
  input  logic                alu_zero,
  output logic                busy
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e              state_q, state_d;
  logic                rr_ptr_q, rr_ptr_d;
  logic                id_q, id_d;
  logic [WIDTH-1:0]    a_q, a_d;
  logic [WIDTH-1:0]    b_q, b_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [WIDTH-1:0]    result_q, result_d;
  logic                zero_q, zero_d;
  logic                any_valid;
  logic                grant;

  // Grant selection: a lone requester wins, a tie goes to rr_ptr.
  always_comb begin
    any_valid = |req_valid;
    if (req_valid == 2'b11) begin
      grant = rr_ptr_q;
    end else begin
      grant = req_valid[1];
    end
  end

  // Next-state, operand latching and handshake outputs.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    id_d       = id_q;
    a_d        = a_q;
    b_d        = b_q;
    ctrl_d     = ctrl_q;
    result_d   = result_q;
    zero_d     = zero_q;
    req_ready  = 2'b00;
    resp_valid = 2'b00;
    unique case (state_q)
      StIdle: begin
        if (any_valid) begin
          req_ready[grant] = 1'b1;
          id_d   = grant;
          a_d    = grant ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
          b_d    = grant ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
          ctrl_d = grant ? req_ctrl[2*CTRL_W-1:CTRL_W] : req_ctrl[CTRL_W-1:0];
          state_d = StExec;
        end
      end
      StExec: begin
        result_d = alu_result;
        zero_d   = alu_zero;
        state_d  = StResp;
      end
      StResp: begin
        resp_valid[id_q] = 1'b1;
        // Only the owner's resp_ready matters; the served side loses priority.
        if (resp_ready[id_q]) begin
          rr_ptr_d = ~id_q;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset drops any op in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      rr_ptr_q <= 1'b0;
      id_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      ctrl_q   <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ctrl_q   <= ctrl_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  // ALU inputs come straight from the latched operands so they never toggle while idle.
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_ctrl    = ctrl_q;
  assign resp_result = result_q;
  assign resp_zero   = zero_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a behavioural ALU closes the loop, a vector table
// exercises single ops, and directed sequences cover stall, fairness and reset.
module tb_alu_share_arbiter;

  localparam int W  = 32;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [2*W-1:0]  req_a;
  logic [2*W-1:0]  req_b;
  logic [2*CW-1:0] req_ctrl;
  logic [1:0]      resp_valid;
  logic [1:0]      resp_ready;
  logic [W-1:0]    resp_result;
  logic            resp_zero;
  logic [W-1:0]    alu_a;
  logic [W-1:0]    alu_b;
  logic [CW-1:0]   alu_ctrl;
  logic [W-1:0]    alu_result;
  logic            alu_zero;
  logic            busy;

  int checks   = 0;
  int failures = 0;

  alu_share_arbiter #(.WIDTH(W), .CTRL_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ctrl   (req_ctrl),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_result(resp_result),
    .resp_zero  (resp_zero),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference ALU: unlisted codes behave as ADD.
  always_comb begin
    case (alu_ctrl)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b1100: alu_result = ~(alu_a | alu_b);
      default: alu_result = alu_a + alu_b;
    endcase
    alu_zero = (alu_result == '0);
  end

  typedef struct {
    int           id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   ctrl;
    logic [W-1:0] exp_result;
    logic         exp_zero;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic drive(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [3:0] ctrl);
    req_a[id*W +: W]    = a;
    req_b[id*W +: W]    = b;
    req_ctrl[id*CW +: CW] = ctrl;
    req_valid[id]       = 1'b1;
  endtask

  // Wait (bounded) for any ready bit; returns 0 on timeout after logging a failure.
  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (req_ready != 2'b00) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: got 00 expected nonzero");
    end
  endtask

  task automatic run_vec(input vec_t v);
    bit ok;
    logic [1:0] bit_id;
    bit_id = 2'b01 << v.id;
    drive(v.id, v.a, v.b, v.ctrl);
    #1;
    wait_ready(ok);
    check("vec_ready", {62'd0, req_ready}, {62'd0, bit_id});
    step();
    req_valid = 2'b00;
    check("vec_exec_busy", {63'd0, busy}, 64'd1);
    check("vec_exec_ctrl", {60'd0, alu_ctrl}, {60'd0, v.ctrl});
    check("vec_exec_a", {32'd0, alu_a}, {32'd0, v.a});
    check("vec_exec_b", {32'd0, alu_b}, {32'd0, v.b});
    step();
    check("vec_resp_valid", {62'd0, resp_valid}, {62'd0, bit_id});
    check("vec_result", {32'd0, resp_result}, {32'd0, v.exp_result});
    check("vec_zero", {63'd0, resp_zero}, {63'd0, v.exp_zero});
    resp_ready = bit_id;
    step();
    resp_ready = 2'b00;
    check("vec_done_valid", {62'd0, resp_valid}, 64'd0);
    check("vec_done_busy", {63'd0, busy}, 64'd0);
    check("vec_hold_ctrl", {60'd0, alu_ctrl}, {60'd0, v.ctrl});
  endtask

  initial begin
    bit ok;
    int grants[$];
    vecs[0] = '{0, 32'd5, 32'd3, 4'b0010, 32'd8, 1'b0};
    vecs[1] = '{1, 32'd7, 32'd7, 4'b0110, 32'd0, 1'b1};
    vecs[2] = '{0, 32'hFFFF_FFFF, 32'd1, 4'b0010, 32'd0, 1'b1};
    vecs[3] = '{1, 32'd0, 32'd0, 4'b1100, 32'hFFFF_FFFF, 1'b0};
    vecs[4] = '{0, 32'd2, 32'd3, 4'b1111, 32'd5, 1'b0};
    vecs[5] = '{1, 32'h0000_00F0, 32'h0000_003C, 4'b0000, 32'h0000_0030, 1'b0};
    vecs[6] = '{0, 32'h0000_00F0, 32'h0000_000F, 4'b0001, 32'h0000_00FF, 1'b0};

    reset      = 1'b1;
    req_valid  = 2'b00;
    req_a      = '0;
    req_b      = '0;
    req_ctrl   = '0;
    resp_ready = 2'b00;
    step();
    step();
    reset = 1'b0;

    // Reset state.
    check("rst_req_ready", {62'd0, req_ready}, 64'd0);
    check("rst_resp_valid", {62'd0, resp_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_result", {32'd0, resp_result}, 64'd0);
    check("rst_zero", {63'd0, resp_zero}, 64'd0);
    check("rst_alu_a", {32'd0, alu_a}, 64'd0);
    check("rst_alu_b", {32'd0, alu_b}, 64'd0);
    check("rst_alu_ctrl", {60'd0, alu_ctrl}, 64'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Stalled response: held stable; the non-owner's resp_ready is ignored.
    drive(1, 32'd7, 32'd7, 4'b0110);
    #1;
    wait_ready(ok);
    check("stall_ready", {62'd0, req_ready}, 64'd2);
    step();
    req_valid = 2'b00;
    step();
    resp_ready = 2'b01;
    for (int c = 0; c < 5; c++) begin
      check("stall_valid", {62'd0, resp_valid}, 64'd2);
      check("stall_result", {32'd0, resp_result}, 64'd0);
      check("stall_zero", {63'd0, resp_zero}, 64'd1);
      check("stall_no_ready", {62'd0, req_ready}, 64'd0);
      step();
    end
    resp_ready = 2'b10;
    step();
    resp_ready = 2'b00;
    check("stall_release", {62'd0, resp_valid}, 64'd0);

    // Both requesters valid continuously: grants alternate from requester 0.
    do_reset();
    drive(0, 32'h0000_000C, 32'h0000_000A, 4'b0000);
    drive(1, 32'h0000_000C, 32'h0000_000A, 4'b0001);
    resp_ready = 2'b11;
    #1;
    for (int c = 0; c < 15; c++) begin
      if (req_ready == 2'b11) check("rr_both_ready", {62'd0, req_ready}, 64'd1);
      if (req_ready != 2'b00) grants.push_back(int'(req_ready[1]));
      if (resp_valid == 2'b01) check("rr_and_result", {32'd0, resp_result}, 64'h8);
      if (resp_valid == 2'b10) check("rr_or_result", {32'd0, resp_result}, 64'hE);
      step();
    end
    req_valid  = 2'b00;
    resp_ready = 2'b00;
    check("rr_grant_count", 64'(grants.size()), 64'd5);
    for (int g = 0; g < 4; g++) begin
      if (g < grants.size()) check("rr_grant_order", 64'(grants[g]), 64'(g % 2));
    end
    step();
    step();
    step();

    // Reset during RESP: op dropped, rr_ptr back to requester 0.
    run_vec(vecs[0]);
    drive(1, 32'd9, 32'd1, 4'b0010);
    #1;
    wait_ready(ok);
    step();
    req_valid = 2'b00;
    step();
    check("mid_resp_valid", {62'd0, resp_valid}, 64'd2);
    do_reset();
    check("mid_rst_valid", {62'd0, resp_valid}, 64'd0);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_result", {32'd0, resp_result}, 64'd0);
    check("mid_rst_alu_a", {32'd0, alu_a}, 64'd0);
    resp_ready = 2'b11;
    for (int c = 0; c < 3; c++) begin
      check("mid_no_late_resp", {62'd0, resp_valid}, 64'd0);
      step();
    end
    resp_ready = 2'b00;
    drive(0, 32'd1, 32'd1, 4'b0010);
    drive(1, 32'd1, 32'd1, 4'b0010);
    #1;
    check("mid_rr_ptr_zero", {62'd0, req_ready}, 64'd1);
    req_valid = 2'b00;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
